// File: rtl/apb_slv_pkg.sv
// Shared types and sizing helpers for the multi-region APB completer.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned MAX_WAIT_CYCLES = 15;
    localparam int unsigned WAIT_CNT_W      = 4;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned sel_width(input int unsigned num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

    // First byte address past the end of one region.
    function automatic int unsigned byte_limit(input int unsigned depth, input int unsigned data_w);
        return depth * (data_w / 8);
    endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// One region's flop storage: byte-enabled write port and a registered read port.
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end
            if (re_i) begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_multi_slave.sv
// APB completer with NUM_SLV isolated flop-based regions and programmable wait states.
// Optional byte strobes are enabled by defining APB_PSTRB_EN.
module apb_multi_slave
    import apb_slv_pkg::*;
#(
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [NUM_SLV-1:0]  PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int unsigned IDX_W      = idx_width(DEPTH);
    localparam int unsigned SEL_W      = sel_width(NUM_SLV);
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned ADDR_LIMIT = byte_limit(DEPTH, DATA_W);
    localparam int unsigned WAIT_LOAD  = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic                  err_q, err_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [SEL_W-1:0]      rd_sel_q, rd_sel_d;
    logic                  rd_err_q, rd_err_d;

    logic                  setup_c;
    logic                  commit_c;
    logic [SEL_W-1:0]      live_sel;
    logic [IDX_W-1:0]      live_idx;
    logic [BE_W-1:0]       live_be;
    logic                  live_err;
    logic [SEL_W-1:0]      cur_sel;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_wr;
    logic [DATA_W-1:0]     cur_wdata;
    logic [BE_W-1:0]       cur_be;
    logic                  cur_err;
    logic [NUM_SLV-1:0]    we;
    logic [NUM_SLV-1:0]    re;
    logic [DATA_W-1:0]     rdata_arr [NUM_SLV];

    assign setup_c  = (|PSEL) & ~PENABLE;
    assign live_idx = PADDR[IDX_W+1:2];

`ifdef APB_PSTRB_EN
    assign live_be = PSTRB;
`else
    assign live_be = '1;
`endif

    // Region index (lowest set bit) and error decode of the live SETUP phase.
    always_comb begin
        live_sel = '0;
        for (int k = int'(NUM_SLV) - 1; k >= 0; k--) begin
            if (PSEL[k]) begin
                live_sel = SEL_W'(k);
            end
        end
        live_err = (PADDR[1:0] != 2'b00)
                 | (PADDR >= ADDR_W'(ADDR_LIMIT))
                 | ($countones(PSEL) > 1);
`ifdef APB_PSTRB_EN
        live_err = live_err | (~PWRITE & (|PSTRB));
`endif
    end

    // A zero-wait commit happens on the SETUP edge itself, before anything is latched.
    always_comb begin
        if (state_q == IDLE) begin
            cur_sel   = live_sel;
            cur_idx   = live_idx;
            cur_wr    = PWRITE;
            cur_wdata = PWDATA;
            cur_be    = live_be;
            cur_err   = live_err;
        end else begin
            cur_sel   = sel_q;
            cur_idx   = idx_q;
            cur_wr    = wr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
            cur_err   = err_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        rd_sel_d  = rd_sel_q;
        rd_err_d  = rd_err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        commit_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup_c) begin
                    sel_d   = live_sel;
                    idx_d   = live_idx;
                    wr_d    = PWRITE;
                    wdata_d = PWDATA;
                    be_d    = live_be;
                    err_d   = live_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        commit_c = 1'b1;
                    end else begin
                        cnt_d   = WAIT_CNT_W'(WAIT_LOAD);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!(|PSEL) || !PENABLE) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end else begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit_c) begin
            pready_d  = 1'b1;
            pslverr_d = cur_err;
            if (!cur_wr) begin
                rd_sel_d = cur_sel;
                rd_err_d = cur_err;
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rd_sel_q  <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            rd_sel_q  <= rd_sel_d;
            rd_err_q  <= rd_err_d;
        end
    end

    for (genvar k = 0; k < int'(NUM_SLV); k++) begin : g_region
        assign we[k] = commit_c &  cur_wr & ~cur_err & (cur_sel == SEL_W'(k));
        assign re[k] = commit_c & ~cur_wr & ~cur_err & (cur_sel == SEL_W'(k));

        apb_slv_regfile #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .IDX_W  (IDX_W)
        ) u_regfile (
            .clk     (clk),
            .rst     (resetn),
            .we_i    (we[k]),
            .re_i    (re[k]),
            .idx_i   (cur_idx),
            .wdata_i (cur_wdata),
            .be_i    (cur_be),
            .rdata_o (rdata_arr[k])
        );
    end

    // Each region's read register holds until its next read; the last read's region and error pick the output.
    assign PRDATA  = rd_err_q ? '0 : rdata_arr[rd_sel_q];
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_multi_slave.sv
// Directed bench: a zero-wait and a three-wait instance share one APB bus.
module tb_apb_multi_slave;

    logic        clk;
    logic        rst;
    logic [31:0] paddr;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd0, rd3;
    logic        er0, er3;
    int          rdy0, rdy3;

    apb_multi_slave #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .resetn(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_multi_slave #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .resetn(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Full transfer: SETUP, then ACCESS held until the slower instance responds (bounded).
    task automatic xfer(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb);
        rdy0 = -1; rdy3 = -1; rd0 = 'x; rd3 = 'x; er0 = 1'bx; er3 = 1'bx;
        psel = sel; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 1; c <= 10 && rdy3 < 0; c++) begin
            if (rdy0 < 0 && pready0) begin rdy0 = c; rd0 = prdata0; er0 = pslverr0; end
            if (pready3) begin rdy3 = c; rd3 = prdata3; er3 = pslverr3; end
            @(posedge clk); #1;
        end
        psel = '0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = '0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({pready0, pslverr0, prdata0} !== 34'h0) begin
            n_err++; $display("FAIL reset_dut0: got %b/%b/%h want 0/0/0", pready0, pslverr0, prdata0);
        end
        n_vec++;
        if ({pready3, pslverr3, prdata3} !== 34'h0) begin
            n_err++; $display("FAIL reset_dut3: got %b/%b/%h want 0/0/0", pready3, pslverr3, prdata3);
        end
    endtask

    task automatic test_basic_rw();
        xfer(1'b1, 4'b0001, 32'h08, 32'hDEADBEEF, 4'hF);
        n_vec++;
        if ({rdy0, rdy3} !== {32'sd1, 32'sd4}) begin
            n_err++; $display("FAIL basic_wr_latency: got %0d/%0d want 1/4", rdy0, rdy3);
        end
        n_vec++;
        if ({er0, er3} !== 2'b00) begin
            n_err++; $display("FAIL basic_wr_err: got %b%b want 00", er0, er3);
        end
        xfer(1'b0, 4'b0001, 32'h08, 32'h0, 4'h0);
        n_vec++;
        if ({rdy0, rdy3} !== {32'sd1, 32'sd4}) begin
            n_err++; $display("FAIL basic_rd_latency: got %0d/%0d want 1/4", rdy0, rdy3);
        end
        n_vec++;
        if ({er0, er3, rd0, rd3} !== {2'b00, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL basic_rd_data: got %b%b %h %h want 00 deadbeef deadbeef", er0, er3, rd0, rd3);
        end
    endtask

    task automatic test_wait_read();
        int low_cnt = 0;
        psel = 4'b0100; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 10 && !pready3; c++) begin
            low_cnt++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (low_cnt !== 3) begin
            n_err++; $display("FAIL wait_low_cycles: got %0d want 3", low_cnt);
        end
        n_vec++;
        if ({pready3, pslverr3, prdata3} !== {2'b10, 32'h0}) begin
            n_err++; $display("FAIL wait_resp: got %b/%b/%h want 1/0/0", pready3, pslverr3, prdata3);
        end
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
        n_vec++;
        if (pready3 !== 1'b0) begin
            n_err++; $display("FAIL wait_pready_one_cycle: got %b want 0", pready3);
        end
    endtask

    task automatic test_isolation();
        xfer(1'b1, 4'b0001, 32'h04, 32'h11, 4'hF);
        xfer(1'b1, 4'b1000, 32'h04, 32'h22, 4'hF);
        xfer(1'b0, 4'b0001, 32'h04, 32'h0, 4'h0);
        n_vec++;
        if ({rd0, rd3} !== {32'h11, 32'h11}) begin
            n_err++; $display("FAIL iso_region0: got %h %h want 11 11", rd0, rd3);
        end
        xfer(1'b0, 4'b1000, 32'h04, 32'h0, 4'h0);
        n_vec++;
        if ({rd0, rd3} !== {32'h22, 32'h22}) begin
            n_err++; $display("FAIL iso_region3: got %h %h want 22 22", rd0, rd3);
        end
    endtask

    task automatic test_errors();
        xfer(1'b1, 4'b0001, 32'h41, 32'h55, 4'hF);
        n_vec++;
        if ({er0, er3} !== 2'b11) begin
            n_err++; $display("FAIL err_misaligned: got %b%b want 11", er0, er3);
        end
        xfer(1'b1, 4'b0001, 32'h40, 32'h77, 4'hF);
        n_vec++;
        if ({er0, er3} !== 2'b11) begin
            n_err++; $display("FAIL err_range_wr: got %b%b want 11", er0, er3);
        end
        xfer(1'b0, 4'b0001, 32'h40, 32'h0, 4'h0);
        n_vec++;
        if ({er0, er3, rd0, rd3} !== {2'b11, 64'h0}) begin
            n_err++; $display("FAIL err_range_rd: got %b%b %h %h want 11 0 0", er0, er3, rd0, rd3);
        end
        xfer(1'b0, 4'b0001, 32'h00, 32'h0, 4'h0);
        n_vec++;
        if ({er0, er3, rd0, rd3} !== {2'b00, 64'h0}) begin
            n_err++; $display("FAIL err_no_write: got %b%b %h %h want 00 0 0", er0, er3, rd0, rd3);
        end
        xfer(1'b1, 4'b0011, 32'h08, 32'h99, 4'hF);
        n_vec++;
        if ({er0, er3} !== 2'b11) begin
            n_err++; $display("FAIL err_multi_sel: got %b%b want 11", er0, er3);
        end
        xfer(1'b0, 4'b0001, 32'h08, 32'h0, 4'h0);
        n_vec++;
        if ({rd0, rd3} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL err_multi_r0: got %h %h want deadbeef deadbeef", rd0, rd3);
        end
        xfer(1'b0, 4'b0010, 32'h08, 32'h0, 4'h0);
        n_vec++;
        if ({rd0, rd3} !== 64'h0) begin
            n_err++; $display("FAIL err_multi_r1: got %h %h want 0 0", rd0, rd3);
        end
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 4'b0010, 32'h3C, 32'h1234, 4'hF);
        xfer(1'b1, 4'b0010, 32'h3C, 32'h5678, 4'hF);
        xfer(1'b0, 4'b0010, 32'h3C, 32'h0, 4'h0);
        n_vec++;
        if ({rdy0, rdy3} !== {32'sd1, 32'sd4}) begin
            n_err++; $display("FAIL b2b_latency: got %0d/%0d want 1/4", rdy0, rdy3);
        end
        n_vec++;
        if ({er0, er3, rd0, rd3} !== {2'b00, 32'h5678, 32'h5678}) begin
            n_err++; $display("FAIL b2b_waw: got %b%b %h %h want 00 5678 5678", er0, er3, rd0, rd3);
        end
    endtask

    task automatic test_abort();
        int saw = 0;
        psel = 4'b0100; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hCAFE; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (pready3) saw++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (saw !== 0) begin
            n_err++; $display("FAIL abort_pready: got %0d ready cycles want 0", saw);
        end
        xfer(1'b0, 4'b0100, 32'h0C, 32'h0, 4'h0);
        n_vec++;
        if ({rd0, rd3} !== {32'hCAFE, 32'h0}) begin
            n_err++; $display("FAIL abort_no_write: got %h %h want cafe 0", rd0, rd3);
        end
    endtask

    task automatic test_reset_mid();
        xfer(1'b1, 4'b1000, 32'h10, 32'hA5A5A5A5, 4'hF);
        psel = 4'b1000; penable = 1'b0; paddr = 32'h10; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({pready0, pslverr0, prdata0, pready3, pslverr3, prdata3} !== 68'h0) begin
            n_err++; $display("FAIL rst_mid_outputs: got %b%b %h %b%b %h want all 0",
                              pready0, pslverr0, prdata0, pready3, pslverr3, prdata3);
        end
        @(posedge clk); #1;
        rst = 1'b0; psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 4'b1000, 32'h10, 32'h0, 4'h0);
        n_vec++;
        if ({er0, er3, rd0, rd3} !== {2'b00, 64'h0}) begin
            n_err++; $display("FAIL rst_mid_storage: got %b%b %h %h want 00 0 0", er0, er3, rd0, rd3);
        end
    endtask

`ifdef APB_PSTRB_EN
    task automatic test_pstrb();
        xfer(1'b1, 4'b0001, 32'h14, 32'h11223344, 4'hF);
        xfer(1'b1, 4'b0001, 32'h14, 32'hAABBCCDD, 4'b0101);
        n_vec++;
        if ({er0, er3} !== 2'b00) begin
            n_err++; $display("FAIL strb_wr_err: got %b%b want 00", er0, er3);
        end
        xfer(1'b1, 4'b0001, 32'h14, 32'hFFFFFFFF, 4'b0000);
        n_vec++;
        if ({er0, er3} !== 2'b00) begin
            n_err++; $display("FAIL strb_zero_err: got %b%b want 00", er0, er3);
        end
        xfer(1'b0, 4'b0001, 32'h14, 32'h0, 4'h0);
        n_vec++;
        if ({rd0, rd3} !== {32'h11BB33DD, 32'h11BB33DD}) begin
            n_err++; $display("FAIL strb_merge: got %h %h want 11bb33dd 11bb33dd", rd0, rd3);
        end
        xfer(1'b0, 4'b0001, 32'h14, 32'h0, 4'b0001);
        n_vec++;
        if ({er0, er3, rd0, rd3} !== {2'b11, 64'h0}) begin
            n_err++; $display("FAIL strb_rd_err: got %b%b %h %h want 11 0 0", er0, er3, rd0, rd3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_rw();
        test_wait_read();
        test_isolation();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef APB_PSTRB_EN
        test_pstrb();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_multi_slave.md
Name: apb_multi_slave

Overview:
- Parametrised APB completer serving NUM_SLV independent slave regions, each selected by one bit of a PSEL vector; generalises the fixed four-select APB signal set to N channels.
- Each region holds DEPTH flop-based words and responds with programmable wait states, PSLVERR on illegal accesses and a registered single-cycle PREADY.
- Sits on the APB side of the AHB-to-APB bridge. Acts as the synthesizable slave model and as the bench's reference responder.

Parameters:
- NUM_SLV, 4, number of slave regions / PSEL bits (1..16)
- ADDR_W, 32, PADDR width
- DATA_W, 32, PWDATA/PRDATA width (multiple of 8)
- DEPTH, 16, words per region (power of 2, >=2)
- WAIT_CYCLES, 0, wait states inserted before PREADY (0..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-high reset (1 = in reset)
- PADDR  in  ADDR_W  byte address
- PSEL  in  NUM_SLV  one-hot region select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_W  write data
- PRDATA  out  DATA_W  read data, valid while PREADY=1
- PREADY  out  1  transfer complete, registered
- PSLVERR  out  1  error response, valid while PREADY=1

Behaviour:
- Reset: async, active-high. PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, wait counter=0, all storage words=0. A reset mid-transfer aborts the transfer with no write committed.
- Storage index is PADDR[log2(DEPTH)+1:2].
- Error conditions, evaluated at the SETUP edge and latched:
  - PADDR[1:0]!=0
  - PADDR >= DEPTH*DATA_W/8
  - more than one PSEL bit set
- States: IDLE, WAIT, RESP.
- IDLE:
  - On (|PSEL & !PENABLE) at a clock edge, latch the region index, address, PWRITE, PWDATA and the error flag.
  - If WAIT_CYCLES==0, go to RESP and commit. Otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT: counter!=0 decrements. At counter==0, go to RESP and commit.
- Commit, on the edge entering RESP:
  - PREADY<=1. PSLVERR<=error flag.
  - Error-free write: storage[region][index] is updated.
  - Error-free read: PRDATA<=storage[region][index].
  - Erroneous write: no storage change.
  - Erroneous read: PRDATA<=0.
- RESP:
  - PREADY=1 for exactly one cycle.
  - Next edge: PREADY<=0, PSLVERR<=0, state IDLE.
  - PRDATA holds its value until the next completed read.
- Latency: a transfer occupies 2+WAIT_CYCLES cycles (SETUP + WAIT_CYCLES waits + 1 ACCESS with PREADY).
- Back-to-back: a SETUP phase in the cycle after RESP is accepted from IDLE with no bubble.
- Protocol violation: PSEL or PENABLE low while in WAIT returns to IDLE, PREADY stays 0, nothing is committed.
- Write-after-write to the same word: the last commit wins. Read-after-write returns the new data.
- Regions are isolated: a write to region k never alters region j.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined:
  - Adds input PSTRB [DATA_W/8], latched at SETUP.
  - A write updates only the bytes whose strobe bit is 1. A write with PSTRB=0 is a no-op with PSLVERR=0.
  - A read with PSTRB!=0 raises PSLVERR and returns PRDATA=0.
- Undefined: no PSTRB port; every write updates the full word.

Decomposition:
- Package apb_slv_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - localparam functions for index width and byte-address limit
  - max WAIT_CYCLES constant and counter width
- Sub-module apb_slv_regfile: one region's DEPTH x DATA_W storage with async reset, write enable, index and optional byte enables, and a registered read port. Instantiated NUM_SLV times via generate.
- The top holds the FSM, decode, error logic and output mux.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to PSEL=0001, PADDR=0x08, then read it back -> PREADY high in the 2nd cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- WAIT_CYCLES=3: read region 2, PADDR=0x0 -> PREADY low for 3 ACCESS cycles, then high for 1 cycle. PRDATA=0 after reset.
- Region isolation: write 0x11 to region 0 and 0x22 to region 3, both at PADDR=0x04, then read both -> 0x11 and 0x22 respectively.
- Errors:
  - PADDR=0x41 with DEPTH=16 -> PSLVERR=1, no write.
  - PADDR=0x40 -> PSLVERR=1.
  - PSEL=0011 -> PSLVERR=1, neither region changed.
- Abort and reset: PSEL dropped in WAIT -> no PREADY, no write. Assert resetn during WAIT -> all outputs 0, a read of the previously written word returns 0.
- APB_PSTRB_EN: write 0xAABBCCDD over 0x11223344 with PSTRB=0101 -> read returns 0x11BB33DD. A read with PSTRB=0001 -> PSLVERR=1.
